// File: rtl/toy_stdio_pkg.sv
// Shared definitions for the stdio stream path: the native word width,
// the word type, and the channel-index width helper used by the merger.
package toy_stdio_pkg;

  localparam int STDIO_W = 16;

  typedef logic [STDIO_W-1:0] stdio_word_t;

  // Width of a channel index; never narrower than one bit so a
  // single-channel build still has a legal out_chan_o port.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stdio_fifo.sv
// One DEPTH-entry synchronous FIFO for a single producer channel.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   flush_i              synchronous clear; pushes/pops in that cycle are dropped
//   push_i, push_data_i  write request and word (ignored while full)
//   pop_i                read request (ignored while empty)
//   head_o               word at the read pointer
//   full_o, empty_o      status flags
//   count_o              occupancy 0..DEPTH
module stdio_fifo
  import toy_stdio_pkg::*;
#(
  parameter int  DATA_W = STDIO_W,
  parameter int  DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o  = (count_r == (AW+1)'(DEPTH));
  assign empty_o = (count_r == (AW+1)'(0));
  assign count_o = count_r;
  assign head_o  = mem_r[rd_ptr_r];

  // Full refuses a push even when a pop frees a slot this cycle.
  assign push_ok_s = push_i && !full_o && !flush_i;
  assign pop_ok_s  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are only visible through count, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data_i;
  end

endmodule

// File: rtl/stdio_merge.sv
// N-channel stdio merger: each channel is buffered in its own FIFO and a
// round-robin arbiter moves one word per cycle into a registered output
// stream tagged with the source channel.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   flush_i                synchronous clear of all buffered and pending data
//   in_val_i/in_rdy_o      per-channel valid/ready
//   in_data_i              channel k at [k*DATA_W +: DATA_W]
//   out_val_o/out_rdy_i    merged stream handshake
//   out_data_o, out_chan_o merged word and its source channel
//   occ_o                  per-channel FIFO occupancy, AW+1 bits each
module stdio_merge
  import toy_stdio_pkg::*;
#(
  parameter int  N_CH   = 2,
  parameter int  DATA_W = STDIO_W,
  parameter int  DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CH_W   = ch_w(N_CH)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic [N_CH-1:0]        in_val_i,
  input  logic [N_CH*DATA_W-1:0] in_data_i,
  output logic [N_CH-1:0]        in_rdy_o,
  output logic                   out_val_o,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [CH_W-1:0]        out_chan_o,
  input  logic                   out_rdy_i,
  output logic [N_CH*(AW+1)-1:0] occ_o
);

  logic [N_CH-1:0]   full_s;
  logic [N_CH-1:0]   empty_s;
  logic [N_CH-1:0]   pop_s;
  logic [DATA_W-1:0] head_s [N_CH];
  logic              load_s;
  logic              gnt_vld_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [CH_W-1:0]   rr_next_s;
  logic [DATA_W-1:0] gnt_data_s;
  logic [CH_W-1:0]   rr_ptr_r;
  logic              out_val_r;
  logic [DATA_W-1:0] out_data_r;
  logic [CH_W-1:0]   out_chan_r;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    stdio_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .push_i      (in_val_i[k]),
      .push_data_i (in_data_i[k*DATA_W +: DATA_W]),
      .pop_i       (pop_s[k]),
      .head_o      (head_s[k]),
      .full_o      (full_s[k]),
      .empty_o     (empty_s[k]),
      .count_o     (occ_o[k*(AW+1) +: AW+1])
    );
    assign in_rdy_o[k] = !full_s[k] && !flush_i;
  end

  // The output slot can take a new word when empty or being drained now.
  assign load_s = !out_val_r || out_rdy_i;

  // Round-robin pick: first scan channels at or above rr_ptr, then wrap
  // to the lowest non-empty channel below it.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (!gnt_vld_s && !empty_s[j] && (j >= int'(rr_ptr_r))) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = CH_W'(j);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (!gnt_vld_s && !empty_s[j]) begin
        gnt_vld_s = 1'b1;
        gnt_idx_s = CH_W'(j);
      end else begin
        gnt_vld_s = gnt_vld_s;
      end
    end
  end

  // Pop strobe and head-word mux for the granted channel.
  always_comb begin
    pop_s      = '0;
    gnt_data_s = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (gnt_idx_s == CH_W'(j)) begin
        pop_s[j]   = load_s && gnt_vld_s && !flush_i;
        gnt_data_s = head_s[j];
      end else begin
        pop_s[j]   = 1'b0;
      end
    end
  end

  assign rr_next_s = (gnt_idx_s == CH_W'(N_CH-1)) ? CH_W'(0) : gnt_idx_s + CH_W'(1);

  // Output register and round-robin pointer; data/chan hold when idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_val_r  <= 1'b0;
      out_data_r <= '0;
      out_chan_r <= '0;
      rr_ptr_r   <= '0;
    end else if (flush_i) begin
      out_val_r  <= 1'b0;
      rr_ptr_r   <= '0;
    end else if (load_s) begin
      if (gnt_vld_s) begin
        out_val_r  <= 1'b1;
        out_data_r <= gnt_data_s;
        out_chan_r <= gnt_idx_s;
        rr_ptr_r   <= rr_next_s;
      end else begin
        out_val_r  <= 1'b0;
      end
    end
  end

  assign out_val_o  = out_val_r;
  assign out_data_o = out_data_r;
  assign out_chan_o = out_chan_r;

endmodule

// File: tb/tb_stdio_merge.sv
// Self-checking bench for stdio_merge (N_CH=2, DEPTH=4). A transaction-level
// model (one queue of tagged words, an output slot and a next-channel
// pointer) is advanced once per clock alongside the DUT.
module tb_stdio_merge;
  import toy_stdio_pkg::*;

  localparam int N_CH   = 2;
  localparam int DATA_W = STDIO_W;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(DEPTH);
  localparam int OW     = AW + 1;
  localparam int CH_W   = ch_w(N_CH);

  logic                   clk_i;
  logic                   rst_ni;
  logic                   flush_i;
  logic [N_CH-1:0]        in_val_i;
  logic [N_CH*DATA_W-1:0] in_data_i;
  logic [N_CH-1:0]        in_rdy_o;
  logic                   out_val_o;
  logic [DATA_W-1:0]      out_data_o;
  logic [CH_W-1:0]        out_chan_o;
  logic                   out_rdy_i;
  logic [N_CH*OW-1:0]     occ_o;

  int total;
  int bad;

  typedef struct packed {
    logic [7:0]  ch;
    stdio_word_t d;
  } ent_t;

  ent_t        mq[$];
  bit          m_val;
  stdio_word_t m_data;
  int          m_chan;
  int          m_rr;

  stdio_merge #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_val_i(in_val_i), .in_data_i(in_data_i), .in_rdy_o(in_rdy_o),
    .out_val_o(out_val_o), .out_data_o(out_data_o), .out_chan_o(out_chan_o),
    .out_rdy_i(out_rdy_i), .occ_o(occ_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int m_occ(int k);
    int n = 0;
    foreach (mq[i]) if (int'(mq[i].ch) == k) n++;
    return n;
  endfunction

  function automatic int d_occ(int k);
    return int'(occ_o[k*OW +: OW]);
  endfunction

  function automatic stdio_word_t word_of(int k, int j);
    return stdio_word_t'(k * 4096 + j);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_val = 1'b0; m_data = '0; m_chan = 0; m_rr = 0;
  endtask

  // Advance the model by one clock using the inputs presented right now.
  task automatic model_step();
    bit acc[N_CH];
    int g;
    if (flush_i) begin
      mq.delete(); m_val = 1'b0; m_rr = 0;
      return;
    end
    for (int k = 0; k < N_CH; k++) acc[k] = in_val_i[k] && (m_occ(k) < DEPTH);
    if (!m_val || out_rdy_i) begin
      g = -1;
      for (int i = 0; i < N_CH; i++)
        if (g < 0 && m_occ((m_rr + i) % N_CH) > 0) g = (m_rr + i) % N_CH;
      if (g >= 0) begin
        for (int i = 0; i < mq.size(); i++)
          if (int'(mq[i].ch) == g) begin
            m_data = mq[i].d; mq.delete(i); break;
          end
        m_chan = g; m_val = 1'b1; m_rr = (g + 1) % N_CH;
      end else m_val = 1'b0;
    end
    for (int k = 0; k < N_CH; k++)
      if (acc[k]) mq.push_back('{ch: 8'(k), d: in_data_i[k*DATA_W +: DATA_W]});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    in_val_i = '0; in_data_i = '0; flush_i = 1'b0; out_rdy_i = 1'b0;
    rst_ni = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++; if (out_val_o !== 1'b0) begin bad++; $display("FAIL reset_val got=%0h want=0", out_val_o); end
    total++; if (out_data_o !== 16'h0000) begin bad++; $display("FAIL reset_data got=%0h want=0", out_data_o); end
    total++; if (out_chan_o !== 1'b0) begin bad++; $display("FAIL reset_chan got=%0h want=0", out_chan_o); end
    total++; if (occ_o !== '0) begin bad++; $display("FAIL reset_occ got=%0h want=0", occ_o); end
    total++; if (in_rdy_o !== 2'b11) begin bad++; $display("FAIL reset_rdy got=%0b want=11", in_rdy_o); end
  endtask

  task automatic test_single();
    out_rdy_i = 1'b0;
    in_val_i = 2'b10; in_data_i[DATA_W +: DATA_W] = 16'h1234;
    tick();
    in_val_i = '0;
    total++; if (out_val_o !== 1'b0) begin bad++; $display("FAIL single_early got=%0h want=0", out_val_o); end
    total++; if (d_occ(1) != 1) begin bad++; $display("FAIL single_occ1 got=%0d want=1", d_occ(1)); end
    tick();
    total++; if (out_val_o !== 1'b1 || out_data_o !== 16'h1234 || out_chan_o !== 1'b1)
      begin bad++; $display("FAIL single_out got=%0h/%0h/%0h want=1/1234/1", out_val_o, out_data_o, out_chan_o); end
    total++; if (d_occ(1) != 0) begin bad++; $display("FAIL single_occ0 got=%0d want=0", d_occ(1)); end
    out_rdy_i = 1'b1;
    tick();
    total++; if (out_val_o !== 1'b0) begin bad++; $display("FAIL single_drain got=%0h want=0", out_val_o); end
    out_rdy_i = 1'b0;
  endtask

  task automatic test_round_robin();
    stdio_word_t exp_d;
    out_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_val_i = 2'b11;
      in_data_i[0 +: DATA_W]      = 16'h00A0 + 16'(i);
      in_data_i[DATA_W +: DATA_W] = 16'h00B0 + 16'(i);
      tick();
    end
    in_val_i = '0;
    total++; if (d_occ(0) != 2 || d_occ(1) != 3) begin bad++; $display("FAIL rr_fill got=%0d/%0d want=2/3", d_occ(0), d_occ(1)); end
    out_rdy_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_d = ((i % 2) == 0 ? 16'h00A0 : 16'h00B0) + 16'(i / 2);
      total++;
      if (out_val_o !== 1'b1 || out_data_o !== exp_d || int'(out_chan_o) != (i % 2)) begin
        bad++; $display("FAIL rr_order[%0d] got=%0h/%0h/%0h want=1/%0h/%0h", i, out_val_o, out_data_o, out_chan_o, exp_d, i % 2);
      end
      tick();
    end
    total++; if (out_val_o !== 1'b0) begin bad++; $display("FAIL rr_end got=%0h want=0", out_val_o); end
    out_rdy_i = 1'b0;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    bit acc;
    out_rdy_i = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_val_i[0] = (sent < 6);
      in_data_i[0 +: DATA_W] = 16'h00C0 + 16'(sent);
      acc = in_val_i[0] && in_rdy_o[0];
      tick();
      if (acc) sent++;
      if (cyc >= 1) begin
        total++;
        if (out_val_o !== 1'b1 || out_data_o !== 16'h00C0 || out_chan_o !== 1'b0) begin
          bad++; $display("FAIL bp_stable[%0d] got=%0h/%0h want=1/c0", cyc, out_val_o, out_data_o);
        end
      end
    end
    total++; if (sent != 5) begin bad++; $display("FAIL bp_accepts got=%0d want=5", sent); end
    total++; if (d_occ(0) != DEPTH) begin bad++; $display("FAIL bp_occ got=%0d want=%0d", d_occ(0), DEPTH); end
    total++; if (in_rdy_o[0] !== 1'b0) begin bad++; $display("FAIL bp_rdy got=%0b want=0", in_rdy_o[0]); end
    out_rdy_i = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 6; cyc++) begin
      in_val_i[0] = (sent < 6);
      in_data_i[0 +: DATA_W] = 16'h00C0 + 16'(sent);
      if (out_val_o === 1'b1) begin
        total++;
        if (out_data_o !== 16'h00C0 + 16'(got)) begin
          bad++; $display("FAIL bp_drain[%0d] got=%0h want=%0h", got, out_data_o, 16'h00C0 + 16'(got));
        end
        got++;
      end
      acc = in_val_i[0] && in_rdy_o[0];
      tick();
      if (acc) sent++;
    end
    in_val_i = '0;
    total++; if (got != 6 || sent != 6) begin bad++; $display("FAIL bp_count got=%0d/%0d want=6/6", got, sent); end
    out_rdy_i = 1'b0;
  endtask

  task automatic test_random();
    int  nsent[N_CH];
    int  nexp[N_CH];
    bit  acc[N_CH];
    int  ch;
    bit  done;
    for (int k = 0; k < N_CH; k++) begin nsent[k] = 0; nexp[k] = 0; end
    done = 1'b0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      for (int k = 0; k < N_CH; k++)
        if (!in_val_i[k] && nsent[k] < 20 && $urandom_range(0, 3) != 0) begin
          in_val_i[k] = 1'b1;
          in_data_i[k*DATA_W +: DATA_W] = word_of(k, nsent[k]);
        end
      out_rdy_i = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N_CH; k++) acc[k] = in_val_i[k] && in_rdy_o[k];
      if (out_val_o && out_rdy_i) begin
        ch = int'(out_chan_o);
        total++;
        if (out_data_o !== word_of(ch, nexp[ch])) begin
          bad++; $display("FAIL rand_order ch%0d got=%0h want=%0h", ch, out_data_o, word_of(ch, nexp[ch]));
        end
        nexp[ch]++;
      end
      tick();
      for (int k = 0; k < N_CH; k++) if (acc[k]) begin nsent[k]++; in_val_i[k] = 1'b0; end
      total++;
      if (out_val_o !== m_val || (m_val && (out_data_o !== m_data || int'(out_chan_o) != m_chan))) begin
        bad++; $display("FAIL rand_out cyc%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", cyc, out_val_o, out_data_o, out_chan_o, m_val, m_data, m_chan);
      end
      for (int k = 0; k < N_CH; k++) begin
        total++;
        if (d_occ(k) != m_occ(k) || d_occ(k) > DEPTH || in_rdy_o[k] !== (m_occ(k) < DEPTH)) begin
          bad++; $display("FAIL rand_occ cyc%0d ch%0d got=%0d/%0b want=%0d", cyc, k, d_occ(k), in_rdy_o[k], m_occ(k));
        end
      end
      done = (nexp[0] == 20) && (nexp[1] == 20);
    end
    total++; if (!done) begin bad++; $display("FAIL rand_timeout got=%0d/%0d want=20/20", nexp[0], nexp[1]); end
    in_val_i = '0; out_rdy_i = 1'b0;
  endtask

  task automatic test_flush();
    out_rdy_i = 1'b0;
    in_val_i = 2'b01; in_data_i[0 +: DATA_W] = 16'h0D00;
    tick();
    for (int i = 1; i <= 3; i++) begin
      in_val_i = 2'b11;
      in_data_i[0 +: DATA_W]      = 16'h0D00 + 16'(i);
      in_data_i[DATA_W +: DATA_W] = 16'h0E00 + 16'(i);
      tick();
    end
    total++; if (out_val_o !== 1'b1 || d_occ(0) != 3 || d_occ(1) != 3)
      begin bad++; $display("FAIL flush_pre got=%0h/%0d/%0d want=1/3/3", out_val_o, d_occ(0), d_occ(1)); end
    flush_i = 1'b1; in_val_i = 2'b11; out_rdy_i = 1'b1;
    #1;
    total++; if (in_rdy_o !== 2'b00) begin bad++; $display("FAIL flush_rdy got=%0b want=00", in_rdy_o); end
    tick();
    flush_i = 1'b0; in_val_i = '0;
    total++; if (out_val_o !== 1'b0 || occ_o !== '0)
      begin bad++; $display("FAIL flush_clear got=%0h/%0h want=0/0", out_val_o, occ_o); end
    in_val_i = 2'b11;
    in_data_i[0 +: DATA_W] = 16'h0F00; in_data_i[DATA_W +: DATA_W] = 16'h0F01;
    tick();
    in_val_i = '0;
    tick();
    total++; if (out_val_o !== 1'b1 || out_chan_o !== 1'b0 || out_data_o !== 16'h0F00)
      begin bad++; $display("FAIL flush_rr0 got=%0h/%0h/%0h want=1/0/f00", out_val_o, out_chan_o, out_data_o); end
    tick();
    total++; if (out_val_o !== 1'b1 || out_chan_o !== 1'b1 || out_data_o !== 16'h0F01)
      begin bad++; $display("FAIL flush_rr1 got=%0h/%0h/%0h want=1/1/f01", out_val_o, out_chan_o, out_data_o); end
    tick();
    out_rdy_i = 1'b0;
  endtask

  task automatic test_async_reset();
    out_rdy_i = 1'b0;
    in_val_i = 2'b11;
    in_data_i[0 +: DATA_W] = 16'h7770; in_data_i[DATA_W +: DATA_W] = 16'h7771;
    tick();
    in_val_i = '0;
    tick();
    total++; if (out_val_o !== 1'b1 || d_occ(1) != 1)
      begin bad++; $display("FAIL areset_pre got=%0h/%0d want=1/1", out_val_o, d_occ(1)); end
    #2 rst_ni = 1'b0;
    #1;
    total++; if (out_val_o !== 1'b0 || out_data_o !== 16'h0000 || occ_o !== '0)
      begin bad++; $display("FAIL areset_now got=%0h/%0h/%0h want=0/0/0", out_val_o, out_data_o, occ_o); end
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++; if (in_rdy_o !== 2'b11 || occ_o !== '0)
      begin bad++; $display("FAIL areset_rel got=%0b/%0h want=11/0", in_rdy_o, occ_o); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_ni = 1'b0; flush_i = 1'b0; out_rdy_i = 1'b0; in_val_i = '0; in_data_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_random();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
